// File: rtl/rv_enc_pkg.sv
// -----------------------------------------------------------------------------
// rv_enc_pkg
// Shared definitions for the RV64IM streaming instruction encoder:
//   enc_op_e     - operation selector presented on in_op
//   fmt_e        - RISC-V instruction layout (R/I/S/B/U/J)
//   chk_e        - immediate range rule applied to an operation
//   OPC_*        - major opcode constants
//   REG_*        - ABI register indices
//   enc_info()   - per-operation lookup of layout, opcode, funct3, funct7
//                  and range rule; valid=0 for unknown/pseudo operations
//   state_e      - output sequencer states
// -----------------------------------------------------------------------------
package rv_enc_pkg;

    typedef enum logic [6:0] {
        ENC_LUI, ENC_AUIPC, ENC_JAL, ENC_JALR,
        ENC_BEQ, ENC_BNE, ENC_BLT, ENC_BGE, ENC_BLTU, ENC_BGEU,
        ENC_LB, ENC_LH, ENC_LW, ENC_LD, ENC_LBU, ENC_LHU, ENC_LWU,
        ENC_SB, ENC_SH, ENC_SW, ENC_SD,
        ENC_ADDI, ENC_SLTI, ENC_SLTIU, ENC_XORI, ENC_ORI, ENC_ANDI,
        ENC_SLLI, ENC_SRLI, ENC_SRAI,
        ENC_ADD, ENC_SUB, ENC_SLL, ENC_SLT, ENC_SLTU, ENC_XOR,
        ENC_SRL, ENC_SRA, ENC_OR, ENC_AND,
        ENC_ADDIW, ENC_SLLIW, ENC_SRLIW, ENC_SRAIW,
        ENC_ADDW, ENC_SUBW, ENC_SLLW, ENC_SRLW, ENC_SRAW,
        ENC_MUL, ENC_MULH, ENC_MULHSU, ENC_MULHU,
        ENC_DIV, ENC_DIVU, ENC_REM, ENC_REMU,
        ENC_MULW, ENC_DIVW, ENC_DIVUW, ENC_REMW, ENC_REMUW,
        ENC_ECALL, ENC_EBREAK,
        // Pseudo-ops: only legal when pseudo expansion is built in
        ENC_LI, ENC_MV, ENC_NOT, ENC_NEG, ENC_SEQZ, ENC_SNEZ, ENC_NOP
    } enc_op_e;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    typedef enum logic [2:0] {
        CHK_NONE,   // no immediate, or immediate is truncated (U-type)
        CHK_I12,    // signed 12 bits
        CHK_B13,    // signed 13 bits, even
        CHK_J21,    // signed 21 bits, even
        CHK_SH6,    // shamt 0..63
        CHK_SH5     // shamt 0..31
    } chk_e;

    typedef enum logic {ST_IDLE, ST_EMIT2} state_e;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;  // SUB/SRA family, bit30
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [4:0] REG_ZERO = 5'd0,  REG_RA  = 5'd1,  REG_SP  = 5'd2,  REG_GP  = 5'd3;
    localparam logic [4:0] REG_TP   = 5'd4,  REG_T0  = 5'd5,  REG_T1  = 5'd6,  REG_T2  = 5'd7;
    localparam logic [4:0] REG_S0   = 5'd8,  REG_S1  = 5'd9,  REG_A0  = 5'd10, REG_A1  = 5'd11;
    localparam logic [4:0] REG_A2   = 5'd12, REG_A3  = 5'd13, REG_A4  = 5'd14, REG_A5  = 5'd15;
    localparam logic [4:0] REG_A6   = 5'd16, REG_A7  = 5'd17, REG_S2  = 5'd18, REG_S3  = 5'd19;
    localparam logic [4:0] REG_S4   = 5'd20, REG_S5  = 5'd21, REG_S6  = 5'd22, REG_S7  = 5'd23;
    localparam logic [4:0] REG_S8   = 5'd24, REG_S9  = 5'd25, REG_S10 = 5'd26, REG_S11 = 5'd27;
    localparam logic [4:0] REG_T3   = 5'd28, REG_T4  = 5'd29, REG_T5  = 5'd30, REG_T6  = 5'd31;

    typedef struct packed {
        logic       valid;
        fmt_e       fmt;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        chk_e       chk;
    } enc_info_t;

    function automatic enc_info_t mk(fmt_e f, logic [6:0] opc, logic [2:0] f3,
                                     logic [6:0] f7, chk_e c);
        enc_info_t r;
        r.valid  = 1'b1;
        r.fmt    = f;
        r.opcode = opc;
        r.funct3 = f3;
        r.funct7 = f7;
        r.chk    = c;
        return r;
    endfunction

    function automatic enc_info_t enc_info(enc_op_e op);
        enc_info_t r;
        r = '0;
        case (op)
            ENC_LUI:    r = mk(FMT_U, OPC_LUI,       3'b000, F7_BASE, CHK_NONE);
            ENC_AUIPC:  r = mk(FMT_U, OPC_AUIPC,     3'b000, F7_BASE, CHK_NONE);
            ENC_JAL:    r = mk(FMT_J, OPC_JAL,       3'b000, F7_BASE, CHK_J21);
            ENC_JALR:   r = mk(FMT_I, OPC_JALR,      3'b000, F7_BASE, CHK_I12);
            ENC_BEQ:    r = mk(FMT_B, OPC_BRANCH,    3'b000, F7_BASE, CHK_B13);
            ENC_BNE:    r = mk(FMT_B, OPC_BRANCH,    3'b001, F7_BASE, CHK_B13);
            ENC_BLT:    r = mk(FMT_B, OPC_BRANCH,    3'b100, F7_BASE, CHK_B13);
            ENC_BGE:    r = mk(FMT_B, OPC_BRANCH,    3'b101, F7_BASE, CHK_B13);
            ENC_BLTU:   r = mk(FMT_B, OPC_BRANCH,    3'b110, F7_BASE, CHK_B13);
            ENC_BGEU:   r = mk(FMT_B, OPC_BRANCH,    3'b111, F7_BASE, CHK_B13);
            ENC_LB:     r = mk(FMT_I, OPC_LOAD,      3'b000, F7_BASE, CHK_I12);
            ENC_LH:     r = mk(FMT_I, OPC_LOAD,      3'b001, F7_BASE, CHK_I12);
            ENC_LW:     r = mk(FMT_I, OPC_LOAD,      3'b010, F7_BASE, CHK_I12);
            ENC_LD:     r = mk(FMT_I, OPC_LOAD,      3'b011, F7_BASE, CHK_I12);
            ENC_LBU:    r = mk(FMT_I, OPC_LOAD,      3'b100, F7_BASE, CHK_I12);
            ENC_LHU:    r = mk(FMT_I, OPC_LOAD,      3'b101, F7_BASE, CHK_I12);
            ENC_LWU:    r = mk(FMT_I, OPC_LOAD,      3'b110, F7_BASE, CHK_I12);
            ENC_SB:     r = mk(FMT_S, OPC_STORE,     3'b000, F7_BASE, CHK_I12);
            ENC_SH:     r = mk(FMT_S, OPC_STORE,     3'b001, F7_BASE, CHK_I12);
            ENC_SW:     r = mk(FMT_S, OPC_STORE,     3'b010, F7_BASE, CHK_I12);
            ENC_SD:     r = mk(FMT_S, OPC_STORE,     3'b011, F7_BASE, CHK_I12);
            ENC_ADDI:   r = mk(FMT_I, OPC_OP_IMM,    3'b000, F7_BASE, CHK_I12);
            ENC_SLTI:   r = mk(FMT_I, OPC_OP_IMM,    3'b010, F7_BASE, CHK_I12);
            ENC_SLTIU:  r = mk(FMT_I, OPC_OP_IMM,    3'b011, F7_BASE, CHK_I12);
            ENC_XORI:   r = mk(FMT_I, OPC_OP_IMM,    3'b100, F7_BASE, CHK_I12);
            ENC_ORI:    r = mk(FMT_I, OPC_OP_IMM,    3'b110, F7_BASE, CHK_I12);
            ENC_ANDI:   r = mk(FMT_I, OPC_OP_IMM,    3'b111, F7_BASE, CHK_I12);
            ENC_SLLI:   r = mk(FMT_I, OPC_OP_IMM,    3'b001, F7_BASE, CHK_SH6);
            ENC_SRLI:   r = mk(FMT_I, OPC_OP_IMM,    3'b101, F7_BASE, CHK_SH6);
            ENC_SRAI:   r = mk(FMT_I, OPC_OP_IMM,    3'b101, F7_ALT,  CHK_SH6);
            ENC_ADD:    r = mk(FMT_R, OPC_OP,        3'b000, F7_BASE, CHK_NONE);
            ENC_SUB:    r = mk(FMT_R, OPC_OP,        3'b000, F7_ALT,  CHK_NONE);
            ENC_SLL:    r = mk(FMT_R, OPC_OP,        3'b001, F7_BASE, CHK_NONE);
            ENC_SLT:    r = mk(FMT_R, OPC_OP,        3'b010, F7_BASE, CHK_NONE);
            ENC_SLTU:   r = mk(FMT_R, OPC_OP,        3'b011, F7_BASE, CHK_NONE);
            ENC_XOR:    r = mk(FMT_R, OPC_OP,        3'b100, F7_BASE, CHK_NONE);
            ENC_SRL:    r = mk(FMT_R, OPC_OP,        3'b101, F7_BASE, CHK_NONE);
            ENC_SRA:    r = mk(FMT_R, OPC_OP,        3'b101, F7_ALT,  CHK_NONE);
            ENC_OR:     r = mk(FMT_R, OPC_OP,        3'b110, F7_BASE, CHK_NONE);
            ENC_AND:    r = mk(FMT_R, OPC_OP,        3'b111, F7_BASE, CHK_NONE);
            ENC_ADDIW:  r = mk(FMT_I, OPC_OP_IMM_32, 3'b000, F7_BASE, CHK_I12);
            ENC_SLLIW:  r = mk(FMT_I, OPC_OP_IMM_32, 3'b001, F7_BASE, CHK_SH5);
            ENC_SRLIW:  r = mk(FMT_I, OPC_OP_IMM_32, 3'b101, F7_BASE, CHK_SH5);
            ENC_SRAIW:  r = mk(FMT_I, OPC_OP_IMM_32, 3'b101, F7_ALT,  CHK_SH5);
            ENC_ADDW:   r = mk(FMT_R, OPC_OP_32,     3'b000, F7_BASE, CHK_NONE);
            ENC_SUBW:   r = mk(FMT_R, OPC_OP_32,     3'b000, F7_ALT,  CHK_NONE);
            ENC_SLLW:   r = mk(FMT_R, OPC_OP_32,     3'b001, F7_BASE, CHK_NONE);
            ENC_SRLW:   r = mk(FMT_R, OPC_OP_32,     3'b101, F7_BASE, CHK_NONE);
            ENC_SRAW:   r = mk(FMT_R, OPC_OP_32,     3'b101, F7_ALT,  CHK_NONE);
            ENC_MUL:    r = mk(FMT_R, OPC_OP,        3'b000, F7_MUL,  CHK_NONE);
            ENC_MULH:   r = mk(FMT_R, OPC_OP,        3'b001, F7_MUL,  CHK_NONE);
            ENC_MULHSU: r = mk(FMT_R, OPC_OP,        3'b010, F7_MUL,  CHK_NONE);
            ENC_MULHU:  r = mk(FMT_R, OPC_OP,        3'b011, F7_MUL,  CHK_NONE);
            ENC_DIV:    r = mk(FMT_R, OPC_OP,        3'b100, F7_MUL,  CHK_NONE);
            ENC_DIVU:   r = mk(FMT_R, OPC_OP,        3'b101, F7_MUL,  CHK_NONE);
            ENC_REM:    r = mk(FMT_R, OPC_OP,        3'b110, F7_MUL,  CHK_NONE);
            ENC_REMU:   r = mk(FMT_R, OPC_OP,        3'b111, F7_MUL,  CHK_NONE);
            ENC_MULW:   r = mk(FMT_R, OPC_OP_32,     3'b000, F7_MUL,  CHK_NONE);
            ENC_DIVW:   r = mk(FMT_R, OPC_OP_32,     3'b100, F7_MUL,  CHK_NONE);
            ENC_DIVUW:  r = mk(FMT_R, OPC_OP_32,     3'b101, F7_MUL,  CHK_NONE);
            ENC_REMW:   r = mk(FMT_R, OPC_OP_32,     3'b110, F7_MUL,  CHK_NONE);
            ENC_REMUW:  r = mk(FMT_R, OPC_OP_32,     3'b111, F7_MUL,  CHK_NONE);
            // Operand fields are forced to zero / 1 by the top for these two
            ENC_ECALL:  r = mk(FMT_I, OPC_SYSTEM,    3'b000, F7_BASE, CHK_NONE);
            ENC_EBREAK: r = mk(FMT_I, OPC_SYSTEM,    3'b000, F7_BASE, CHK_NONE);
            default:    r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv_enc_format.sv
// -----------------------------------------------------------------------------
// rv_enc_format
// Combinational packer for one 32-bit RISC-V instruction word.
// Ports:
//   fmt       in  3   fmt_e layout selector
//   opcode    in  7   major opcode
//   funct3    in  3   funct3 field
//   funct7    in  7   funct7 field (also supplies imm[11:5] of immediate shifts)
//   chk       in  3   chk_e immediate range rule
//   rd/rs1/rs2 in 5   register indices
//   imm       in  32  signed immediate
//   word      out 32  packed instruction
//   range_ok  out 1   immediate satisfies the range rule
// -----------------------------------------------------------------------------
module rv_enc_format
    import rv_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [2:0]  chk,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_ok
);

    logic [11:0] imm_i;

    // NOTE: every combinational output gets a default first, so no path
    // through the case statements leaves a value unassigned (no latch).
    always_comb begin
        imm_i    = imm[11:0];
        word     = '0;
        range_ok = 1'b0;

        // Immediate shifts carry funct7 in the upper immediate bits; for the
        // 6-bit RV64 shamt only funct7[6:1] fits, which still places bit30.
        case (chk_e'(chk))
            CHK_SH6: imm_i = {funct7[6:1], imm[5:0]};
            CHK_SH5: imm_i = {funct7, imm[4:0]};
            default: imm_i = imm[11:0];
        endcase

        case (fmt_e'(fmt))
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: word = {imm_i, rs1, funct3, rd, opcode};
            FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: word = {imm[19:0], rd, opcode};
            FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word = '0;
        endcase

        // A signed N-bit value has all bits from N-1 upward equal.
        case (chk_e'(chk))
            CHK_NONE: range_ok = 1'b1;
            CHK_I12:  range_ok = (&imm[31:11]) | ~(|imm[31:11]);
            CHK_B13:  range_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
            CHK_J21:  range_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
            CHK_SH6:  range_ok = ~(|imm[31:6]);
            CHK_SH5:  range_ok = ~(|imm[31:5]);
            default:  range_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv64_inst_encoder.sv
// -----------------------------------------------------------------------------
// rv64_inst_encoder
// Streaming RV64IM assembler: accepts (op, rd, rs1, rs2, imm) requests and
// emits 32-bit instruction words tagged with their address.
// Optional feature macro: ENC_PSEUDO_EN enables LI/MV/NOT/NEG/SEQZ/SNEZ/NOP,
// including the two-word LUI+ADDIW form of LI. Without it those ops are
// rejected as illegal and the EMIT2 state is never entered.
// Parameters:
//   PC_RESET     address of the first word emitted after reset
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   in_valid/in_ready, in_op, in_rd, in_rs1, in_rs2, in_imm   request
//   out_valid/out_ready, out_inst, out_pc                     output word
//   err_illegal  one-cycle pulse the cycle after a rejected request
//   busy         output word pending or second word outstanding
// -----------------------------------------------------------------------------
module rv64_inst_encoder
    import rv_enc_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
    output logic        err_illegal,
    output logic        busy
);

    state_e      state_q;
    logic        out_valid_q;
    logic [31:0] out_inst_q;
    logic [63:0] out_pc_q;
    logic        err_q;
    logic [31:0] pend_q;

    enc_op_e     op_sel;
    logic [4:0]  rd_sel, rs1_sel, rs2_sel;
    logic [31:0] imm_sel;
    logic        two_word;
    enc_info_t   info;
    logic [31:0] main_word;
    logic        main_ok;
    logic [31:0] pend_word;
    logic        pend_ok;
    logic        req_ok;
    logic        accept;
    logic        out_fire;

`ifdef ENC_PSEUDO_EN
    // LI split: rounding by 0x800 compensates the sign-extension of lo.
    logic [31:0] li_sum;
    logic [19:0] li_hi;
    logic [11:0] li_lo;
    logic        li_fits12;

    assign li_sum    = in_imm + 32'h0000_0800;
    assign li_hi     = li_sum[31:12];
    assign li_lo     = in_imm[11:0];
    assign li_fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
`endif

    // Map the request onto a base operation and its effective operands.
    always_comb begin
        op_sel   = enc_op_e'(in_op);
        rd_sel   = in_rd;
        rs1_sel  = in_rs1;
        rs2_sel  = in_rs2;
        imm_sel  = in_imm;
        two_word = 1'b0;
        case (enc_op_e'(in_op))
            ENC_ECALL: begin
                rd_sel = REG_ZERO; rs1_sel = REG_ZERO; rs2_sel = REG_ZERO; imm_sel = 32'd0;
            end
            ENC_EBREAK: begin
                rd_sel = REG_ZERO; rs1_sel = REG_ZERO; rs2_sel = REG_ZERO; imm_sel = 32'd1;
            end
`ifdef ENC_PSEUDO_EN
            ENC_LI: begin
                if (li_fits12) begin
                    op_sel  = ENC_ADDI;
                    rs1_sel = REG_ZERO;
                end else begin
                    op_sel   = ENC_LUI;
                    imm_sel  = {12'd0, li_hi};
                    two_word = (li_lo != 12'd0);
                end
            end
            ENC_MV:   begin op_sel = ENC_ADDI;  imm_sel = 32'd0; end
            ENC_NOT:  begin op_sel = ENC_XORI;  imm_sel = 32'hFFFF_FFFF; end
            ENC_NEG:  begin op_sel = ENC_SUB;   rs1_sel = REG_ZERO; end
            ENC_SEQZ: begin op_sel = ENC_SLTIU; imm_sel = 32'd1; end
            ENC_SNEZ: begin op_sel = ENC_SLTU;  rs1_sel = REG_ZERO; end
            ENC_NOP:  begin
                op_sel = ENC_ADDI; rd_sel = REG_ZERO; rs1_sel = REG_ZERO; imm_sel = 32'd0;
            end
`endif
            default: ;
        endcase
    end

    assign info = enc_info(op_sel);

    rv_enc_format u_fmt_main (
        .fmt      (info.fmt),
        .opcode   (info.opcode),
        .funct3   (info.funct3),
        .funct7   (info.funct7),
        .chk      (info.chk),
        .rd       (rd_sel),
        .rs1      (rs1_sel),
        .rs2      (rs2_sel),
        .imm      (imm_sel),
        .word     (main_word),
        .range_ok (main_ok)
    );

`ifdef ENC_PSEUDO_EN
    // Second LI word: addiw rd, rd, sext(lo).
    rv_enc_format u_fmt_pend (
        .fmt      (FMT_I),
        .opcode   (OPC_OP_IMM_32),
        .funct3   (3'b000),
        .funct7   (F7_BASE),
        .chk      (CHK_NONE),
        .rd       (in_rd),
        .rs1      (in_rd),
        .rs2      (REG_ZERO),
        .imm      ({{20{li_lo[11]}}, li_lo}),
        .word     (pend_word),
        .range_ok (pend_ok)
    );
`else
    assign pend_word = 32'd0;
    assign pend_ok   = 1'b1;
`endif

    assign req_ok   = info.valid && main_ok && (!two_word || pend_ok);
    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'd0;
            out_pc_q    <= PC_RESET;
            err_q       <= 1'b0;
            pend_q      <= 32'd0;
        end else begin
            err_q <= accept && !req_ok;
            if (out_fire) begin
                out_pc_q <= out_pc_q + 64'd4;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept && req_ok) begin
                        out_valid_q <= 1'b1;
                        out_inst_q  <= main_word;
                        if (two_word) begin
                            pend_q  <= pend_word;
                            state_q <= ST_EMIT2;
                        end
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                    end
                end
                ST_EMIT2: begin
                    // out_valid stays high: word 2 replaces word 1 on its handshake
                    if (out_fire) begin
                        out_inst_q <= pend_q;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_inst    = out_inst_q;
    assign out_pc      = out_pc_q;
    assign err_illegal = err_q;
    assign busy        = out_valid_q || (state_q != ST_IDLE);

endmodule

// File: tb/tb_rv64_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_rv64_inst_encoder
// Directed bench for rv64_inst_encoder with hand-encoded expected words.
// Pseudo-op scenarios are compiled when ENC_PSEUDO_EN is defined.
// -----------------------------------------------------------------------------
module tb_rv64_inst_encoder;
    import rv_enc_pkg::*;

    localparam logic [63:0] PC0 = 64'h0000_0000_0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        err_illegal;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_pc;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    rv64_inst_encoder #(.PC_RESET(PC0)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .err_illegal (err_illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Present one request for exactly one clock edge; returns at edge+1.
    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset.out_valid got=%0b want=0", out_valid); end
        total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL reset.out_inst got=%h want=0", out_inst); end
        total++; if (out_pc !== PC0) begin bad++; $display("FAIL reset.out_pc got=%h want=%h", out_pc, PC0); end
        total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL reset.err got=%0b want=0", err_illegal); end
        total++; if ({in_ready, busy} !== 2'b10) begin bad++; $display("FAIL reset.ready_busy got=%b want=10", {in_ready, busy}); end
        exp_pc = PC0;
    endtask

    task automatic test_encode();
        vec_t v[16];
        v = '{
            '{ENC_ADD,    5'd10, 5'd11, 5'd12, 32'd0,          32'h00C58533},
            '{ENC_ADDI,   5'd2,  5'd2,  5'd0,  32'hFFFF_FFF0,  32'hFF010113},
            '{ENC_JAL,    5'd1,  5'd0,  5'd0,  32'd2048,       32'h001000EF},
            '{ENC_SRAI,   5'd5,  5'd6,  5'd0,  32'd63,         32'h43F35293},
            '{ENC_SD,     5'd0,  5'd2,  5'd12, 32'hFFFF_FFF8,  32'hFEC13C23},
            '{ENC_BEQ,    5'd0,  5'd1,  5'd2,  32'hFFFF_FFFC,  32'hFE208EE3},
            '{ENC_MUL,    5'd10, 5'd11, 5'd12, 32'd0,          32'h02C58533},
            '{ENC_ADDI,   5'd1,  5'd0,  5'd0,  32'd2047,       32'h7FF00093},
            '{ENC_ADDI,   5'd1,  5'd0,  5'd0,  32'hFFFF_F800,  32'h80000093},
            '{ENC_SLLIW,  5'd1,  5'd1,  5'd0,  32'd31,         32'h01F0909B},
            '{ENC_SRAIW,  5'd5,  5'd6,  5'd0,  32'd31,         32'h41F3529B},
            '{ENC_LUI,    5'd5,  5'd0,  5'd0,  32'h000A_BCDE,  32'hABCDE2B7},
            '{ENC_LD,     5'd10, 5'd2,  5'd0,  32'd16,         32'h01013503},
            '{ENC_SUBW,   5'd10, 5'd11, 5'd12, 32'd0,          32'h40C5853B},
            '{ENC_ECALL,  5'd7,  5'd7,  5'd7,  32'd5,          32'h00000073},
            '{ENC_EBREAK, 5'd3,  5'd4,  5'd5,  32'd9,          32'h00100073}
        };
        // out_ready stays high, so each word drains on the edge that accepts the next
        for (int i = 0; i < 16; i++) begin
            drive(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            total++;
            if ({out_valid, out_inst, out_pc} !== {1'b1, v[i].exp, exp_pc}) begin
                bad++;
                $display("FAIL encode[%0d] got v=%0b inst=%h pc=%h want v=1 inst=%h pc=%h",
                         i, out_valid, out_inst, out_pc, v[i].exp, exp_pc);
            end
            exp_pc = exp_pc + 64'd4;
        end
        @(posedge clk); #1;
        total++;
        if ({out_valid, out_pc} !== {1'b0, exp_pc}) begin
            bad++;
            $display("FAIL encode.drain got v=%0b pc=%h want v=0 pc=%h", out_valid, out_pc, exp_pc);
        end
    endtask

    task automatic test_illegal();
        vec_t v[9];
        int   n;
        v[0] = '{ENC_BEQ,   5'd0, 5'd1, 5'd2, 32'd3,         32'h0};
        v[1] = '{ENC_SLLI,  5'd1, 5'd1, 5'd0, 32'd64,        32'h0};
        v[2] = '{ENC_ADDI,  5'd1, 5'd0, 5'd0, 32'd2048,      32'h0};
        v[3] = '{ENC_SLLIW, 5'd1, 5'd1, 5'd0, 32'd32,        32'h0};
        v[4] = '{ENC_JAL,   5'd1, 5'd0, 5'd0, 32'd1,         32'h0};
        v[5] = '{ENC_BNE,   5'd0, 5'd1, 5'd2, 32'd4096,      32'h0};
        v[6] = '{ENC_SLLI,  5'd1, 5'd1, 5'd0, 32'hFFFF_FFFF, 32'h0};
        v[7] = '{7'h7F,     5'd1, 5'd1, 5'd1, 32'd0,         32'h0};
        v[8] = '{ENC_LI,    5'd10, 5'd0, 5'd0, 32'd5,        32'h0};
`ifdef ENC_PSEUDO_EN
        n = 8;
`else
        n = 9;
`endif
        for (int i = 0; i < n; i++) begin
            drive(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            total++;
            if ({err_illegal, out_valid} !== 2'b10) begin
                bad++;
                $display("FAIL illegal[%0d] got err=%0b v=%0b want err=1 v=0", i, err_illegal, out_valid);
            end
        end
        @(posedge clk); #1;
        total++;
        if ({err_illegal, out_valid, out_pc} !== {2'b00, exp_pc}) begin
            bad++;
            $display("FAIL illegal.after got err=%0b v=%0b pc=%h want err=0 v=0 pc=%h",
                     err_illegal, out_valid, out_pc, exp_pc);
        end
    endtask

`ifdef ENC_PSEUDO_EN
    task automatic test_pseudo();
        vec_t s[9];
        vec_t d[2];
        logic [31:0] w2[2];
        s = '{
            '{ENC_LI,   5'd10, 5'd0, 5'd0, 32'h0001_2000, 32'h00012537},
            '{ENC_LI,   5'd1,  5'd0, 5'd0, 32'd5,         32'h00500093},
            '{ENC_LI,   5'd10, 5'd0, 5'd0, 32'hFFFF_F800, 32'h80000513},
            '{ENC_MV,   5'd5,  5'd6, 5'd0, 32'd0,         32'h00030293},
            '{ENC_NOT,  5'd5,  5'd6, 5'd0, 32'd0,         32'hFFF34293},
            '{ENC_NEG,  5'd5,  5'd0, 5'd6, 32'd0,         32'h406002B3},
            '{ENC_SEQZ, 5'd5,  5'd6, 5'd0, 32'd0,         32'h00133293},
            '{ENC_SNEZ, 5'd5,  5'd0, 5'd6, 32'd0,         32'h006032B3},
            '{ENC_NOP,  5'd9,  5'd9, 5'd9, 32'd7,         32'h00000013}
        };
        for (int i = 0; i < 9; i++) begin
            drive(s[i].op, s[i].rd, s[i].rs1, s[i].rs2, s[i].imm);
            total++;
            if ({out_valid, out_inst, out_pc, in_ready} !== {1'b1, s[i].exp, exp_pc, 1'b1}) begin
                bad++;
                $display("FAIL pseudo[%0d] got v=%0b inst=%h pc=%h rdy=%0b want v=1 inst=%h pc=%h rdy=1",
                         i, out_valid, out_inst, out_pc, in_ready, s[i].exp, exp_pc);
            end
            exp_pc = exp_pc + 64'd4;
        end
        d[0] = '{ENC_LI, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, 32'h12346537}; w2[0] = 32'hFFF5051B;
        d[1] = '{ENC_LI, 5'd10, 5'd0, 5'd0, 32'h0000_0800, 32'h00001537}; w2[1] = 32'h8005051B;
        for (int i = 0; i < 2; i++) begin
            drive(d[i].op, d[i].rd, d[i].rs1, d[i].rs2, d[i].imm);
            total++;
            if ({out_valid, out_inst, out_pc, in_ready, busy} !== {1'b1, d[i].exp, exp_pc, 2'b01}) begin
                bad++;
                $display("FAIL li2[%0d].w1 got v=%0b inst=%h pc=%h rdy=%0b busy=%0b want v=1 inst=%h pc=%h rdy=0 busy=1",
                         i, out_valid, out_inst, out_pc, in_ready, busy, d[i].exp, exp_pc);
            end
            exp_pc = exp_pc + 64'd4;
            @(posedge clk); #1;
            total++;
            if ({out_valid, out_inst, out_pc, in_ready} !== {1'b1, w2[i], exp_pc, 1'b1}) begin
                bad++;
                $display("FAIL li2[%0d].w2 got v=%0b inst=%h pc=%h rdy=%0b want v=1 inst=%h pc=%h rdy=1",
                         i, out_valid, out_inst, out_pc, in_ready, w2[i], exp_pc);
            end
            exp_pc = exp_pc + 64'd4;
        end
        @(posedge clk); #1;
        total++;
        if ({out_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL pseudo.drain got v=%0b busy=%0b want 0 0", out_valid, busy);
        end
    endtask
`endif

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(ENC_ADD, 5'd10, 5'd11, 5'd12, 32'd0);
        // Second request waits while the first word is stalled
        in_op = ENC_ADDI; in_rd = 5'd2; in_rs1 = 5'd2; in_rs2 = 5'd0; in_imm = 32'hFFFF_FFF0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if ({out_valid, out_inst, out_pc, in_ready} !== {1'b1, 32'h00C58533, exp_pc, 1'b0}) begin
                bad++;
                $display("FAIL b2b.stall[%0d] got v=%0b inst=%h pc=%h rdy=%0b want v=1 inst=00c58533 pc=%h rdy=0",
                         c, out_valid, out_inst, out_pc, in_ready, exp_pc);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b.ready got=%0b want=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_pc = exp_pc + 64'd4;
        total++;
        if ({out_valid, out_inst, out_pc} !== {1'b1, 32'hFF010113, exp_pc}) begin
            bad++;
            $display("FAIL b2b.second got v=%0b inst=%h pc=%h want v=1 inst=ff010113 pc=%h",
                     out_valid, out_inst, out_pc, exp_pc);
        end
        exp_pc = exp_pc + 64'd4;
        @(posedge clk); #1;
        total++;
        if ({out_valid, out_pc} !== {1'b0, exp_pc}) begin
            bad++;
            $display("FAIL b2b.drain got v=%0b pc=%h want v=0 pc=%h", out_valid, out_pc, exp_pc);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
`ifdef ENC_PSEUDO_EN
        drive(ENC_LI, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
        total++;
        if ({in_ready, busy} !== 2'b01) begin
            bad++;
            $display("FAIL rstmid.emit2 got rdy=%0b busy=%0b want rdy=0 busy=1", in_ready, busy);
        end
`else
        drive(ENC_ADD, 5'd10, 5'd11, 5'd12, 32'd0);
        total++;
        if ({out_valid, busy} !== 2'b11) begin
            bad++;
            $display("FAIL rstmid.stall got v=%0b busy=%0b want 1 1", out_valid, busy);
        end
`endif
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if ({out_valid, out_pc, busy, in_ready} !== {1'b0, PC0, 2'b01}) begin
            bad++;
            $display("FAIL rstmid.after got v=%0b pc=%h busy=%0b rdy=%0b want v=0 pc=%h busy=0 rdy=1",
                     out_valid, out_pc, busy, in_ready, PC0);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rstmid.quiet[%0d] got v=%0b inst=%h want v=0", c, out_valid, out_inst);
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        exp_pc = PC0;
        test_reset();
        test_encode();
        test_illegal();
`ifdef ENC_PSEUDO_EN
        test_pseudo();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
